alu_io_frame_driver: RTL and testbench

- Downstream stage of the dual 8-bit ALU macro. Accepts result frames over a valid/ready handshake: ALU_Out1, ALU_Out2, CarryOut1 and CarryOut2.
- Buffers frames in a small FIFO. Presents each frame on mprj_io[26:0] for a fixed number of cycles so a slow GPIO/firmware monitor can sample it.
- Adds an 8-bit frame sequence number on [25:18] and a toggle strobe on [26].

---
 rtl/alu_io_pkg.sv | 42 ++++
 rtl/alu_io_fifo.sv | 49 ++++
 rtl/alu_io_frame_driver.sv | 142 ++++++++++++++
 tb/tb_alu_io_frame_driver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_io_pkg.sv
// Shared types and pin map for the ALU result frame driver.
// Frames are packed {c2, c1, out2, out1} so they map straight onto io_out[17:0].
package alu_io_pkg;

  localparam int unsigned FRAME_W  = 18;
  localparam int unsigned SEQ_W    = 8;
  localparam int unsigned OUT1_LSB = 0;
  localparam int unsigned OUT2_LSB = 8;
  localparam int unsigned C1_BIT   = 16;
  localparam int unsigned C2_BIT   = 17;
  localparam int unsigned SEQ_LSB  = 18;
  localparam int unsigned STB_BIT  = 26;
  localparam int unsigned IO_W     = 27;

  typedef struct packed {
    logic       c2;
    logic       c1;
    logic [7:0] out2;
    logic [7:0] out1;
  } frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Assemble the pin word from the held frame, sequence number and strobe.
  function automatic logic [IO_W-1:0] pack_pins(input frame_t f,
                                                input logic [SEQ_W-1:0] seq,
                                                input logic stb);
    logic [IO_W-1:0] w;
    w = '0;
    w[OUT1_LSB +: 8]     = f.out1;
    w[OUT2_LSB +: 8]     = f.out2;
    w[C1_BIT]            = f.c1;
    w[C2_BIT]            = f.c2;
    w[SEQ_LSB +: SEQ_W]  = seq;
    w[STB_BIT]           = stb;
    return w;
  endfunction

endpackage

// File: rtl/alu_io_fifo.sv
// Synchronous DEPTH x FRAME_W FIFO; the extra pointer bit separates full from empty.
module alu_io_fifo
  import alu_io_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  logic   push,
  input  logic   pop,
  input  frame_t wdata,
  output frame_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  frame_t          mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic            do_push;
  logic            do_pop;

  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;

  // Pointer bookkeeping; clear drops every stored entry.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/alu_io_frame_driver.sv
// Queues ALU result frames and holds each on the GPIO pins for HOLD_CYCLES cycles,
// tagging it with a sequence number and a toggle strobe for a slow monitor.
module alu_io_frame_driver
  import alu_io_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      alu_out1,
  input  logic [7:0]      alu_out2,
  input  logic            carry1,
  input  logic            carry2,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb,
  output logic            busy,
  output logic            overflow
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              load_c;
  logic              push_c;
  logic              active;
  logic              full;
  logic              empty;
  frame_t            in_frame;
  frame_t            head;
  frame_t            pins;
  logic [SEQ_W-1:0]  seq;
  logic              stb;

  assign in_frame = '{c2: carry2, c1: carry1, out2: alu_out2, out1: alu_out1};

  // active gates in_ready low while in reset; afterwards in_ready tracks !full only.
  assign in_ready = active & ~full;
  assign push_c   = in_valid & in_ready & ~clear;

  alu_io_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clear (clear),
    .push  (push_c),
    .pop   (load_c),
    .wdata (in_frame),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: clear wins, otherwise hold for HOLD_CYCLES then chain or go idle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state_nxt = HOLD;
            cnt_nxt   = CNT_RELOAD;
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
          end else if (!empty) begin
            cnt_nxt = CNT_RELOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Pop/load decision; the FIFO's empty flag only sees pushes from earlier edges.
  always_comb begin
    load_c = 1'b0;
    if (!clear && !empty) begin
      case (state)
        IDLE:    load_c = 1'b1;
        HOLD:    load_c = (cnt == '0);
        default: load_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pins     <= '0;
      seq      <= '0;
      stb      <= 1'b0;
      active   <= 1'b0;
      io_oeb   <= '1;
      overflow <= 1'b0;
    end else begin
      active <= 1'b1;
      io_oeb <= '0;
      if (in_valid && full) overflow <= 1'b1;
      if (clear) begin
        seq <= '0;
        stb <= 1'b0;
      end else if (load_c) begin
        pins <= head;
        seq  <= seq + SEQ_W'(1);
        stb  <= ~stb;
      end
    end
  end

  assign io_out = pack_pins(pins, seq, stb);
  assign busy   = ~empty | (state == HOLD);

endmodule

// File: tb/tb_alu_io_frame_driver.sv
// Bench for alu_io_frame_driver: queue-based reference model compared every cycle,
// plus directed literal checks of reset, latency, hold period, overflow, clear and reset.
module tb_alu_io_frame_driver;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  alu_out1;
  logic [7:0]  alu_out2;
  logic        carry1;
  logic        carry2;
  logic [26:0] io_out;
  logic [26:0] io_oeb;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_io_frame_driver #(
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_out1 (alu_out1),
    .alu_out2 (alu_out2),
    .carry1   (carry1),
    .carry2   (carry2),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .busy     (busy),
    .overflow (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame queue plus "frame on pins, cycles left" bookkeeping.
  logic [17:0] mq[$];
  logic [17:0] m_pins;
  int          m_rem;
  bit          m_hold;
  int          m_seq;
  bit          m_stb;
  bit          m_ovf;
  bit          m_active;
  bit          m_started = 1'b0;

  task automatic model_step();
    bit can_push;
    if (rst) begin
      mq.delete();
      m_pins = '0; m_rem = 0; m_hold = 0; m_seq = 0; m_stb = 0;
      m_ovf = 0; m_active = 0;
    end else begin
      can_push = in_valid && m_active && (mq.size() < DEPTH);
      if (in_valid && mq.size() == DEPTH) m_ovf = 1;
      m_active = 1;
      if (clear) begin
        mq.delete();
        m_seq = 0; m_stb = 0; m_hold = 0; m_rem = 0;
      end else begin
        if (m_hold && m_rem > 0) begin
          m_rem--;
        end else if (mq.size() > 0) begin
          m_pins = mq.pop_front();
          m_rem  = HOLD - 1;
          m_seq  = (m_seq + 1) % 256;
          m_stb  = !m_stb;
          m_hold = 1;
        end else begin
          m_hold = 0;
        end
        if (can_push) mq.push_back({carry2, carry1, alu_out2, alu_out1});
      end
    end
    m_started = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare every cycle on the falling edge.
  initial forever begin
    @(negedge clk);
    if (m_started) begin
      chk("m_io_out",   {5'd0, io_out}, {5'd0, m_stb, 8'(m_seq), m_pins});
      chk("m_io_oeb",   {5'd0, io_oeb}, m_active ? 32'd0 : 32'h07FF_FFFF);
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, m_active && (mq.size() < DEPTH)});
      chk("m_busy",     {31'd0, busy}, {31'd0, (mq.size() > 0) || m_hold});
      chk("m_overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] o1, input logic [7:0] o2,
                       input logic c1, input logic c2);
    in_valid = v; alu_out1 = o1; alu_out2 = o2; carry1 = c1; carry2 = c2;
  endtask

  task automatic drive_rand(input logic v);
    drive(v, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    int acc;
    int cyc;
    rst = 1'b1; clear = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_io_out",   {5'd0, io_out}, 32'd0);
      chk("rst_io_oeb",   {5'd0, io_oeb}, 32'h07FF_FFFF);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_busy",     {31'd0, busy}, 32'd0);
    end
    rst = 1'b0;
    tick();
    chk("rel_io_oeb",   {5'd0, io_oeb}, 32'd0);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Single frame: visible one edge after push, held HOLD cycles.
    drive(1'b1, 8'h3C, 8'hA5, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    chk("single_load", {5'd0, io_out}, 32'h0405_A53C);
    chk("single_busy1", {31'd0, busy}, 32'd1);
    repeat (3) tick();
    chk("single_held", {5'd0, io_out}, 32'h0405_A53C);
    chk("single_busy4", {31'd0, busy}, 32'd1);
    tick();
    chk("single_idle", {31'd0, busy}, 32'd0);

    // Back-to-back frames after a clear: seq 1,2,3 and strobe 1,0,1.
    clear = 1'b1; tick(); clear = 1'b0; tick();
    chk("clr_seq_zero", {5'd0, io_out}, 32'h0001_A53C);
    drive(1'b1, 8'h01, 8'h00, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h02, 8'h00, 1'b0, 1'b0); tick();
    chk("b2b_f1", {5'd0, io_out}, 32'h0404_0001);
    drive(1'b1, 8'h03, 8'h00, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) tick();
    chk("b2b_f1_held", {5'd0, io_out}, 32'h0404_0001);
    tick();
    chk("b2b_f2", {5'd0, io_out}, 32'h0008_0002);
    repeat (4) tick();
    chk("b2b_f3", {5'd0, io_out}, 32'h040C_0003);
    repeat (10) tick();

    // Continuous offer fills the FIFO, stalls and sets sticky overflow.
    chk("ovf_before", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive_rand(1'b1);
      tick();
      if (i == 4) chk("fill_not_ready", {31'd0, in_ready}, 32'd0);
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("ovf_after", {31'd0, overflow}, 32'd1);
    repeat (30) tick();
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Random traffic with occasional clears.
    for (int i = 0; i < 1500; i++) begin
      drive_rand($urandom_range(0, 99) < 55);
      clear = ($urandom_range(0, 63) == 0);
      tick();
    end
    clear = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (30) tick();

    // 257-frame stream from a cleared sequence: seq wraps through 0.
    clear = 1'b1; tick(); clear = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 257 && cyc < 3000) begin
      drive_rand(1'b1);
      if (in_ready) acc++;
      tick();
      cyc++;
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("stream_accepted", 32'(acc), 32'd257);
    repeat (30) tick();
    chk("stream_seq_stb", {23'd0, io_out[26:18]}, 32'h0000_0101);
    chk("stream_idle", {31'd0, busy}, 32'd0);

    // clear during HOLD beats a simultaneous push; data bits retained.
    drive(1'b1, 8'h55, 8'hAA, 1'b0, 1'b1); tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0); repeat (2) tick();
    clear = 1'b1;
    drive(1'b1, 8'h77, 8'h66, 1'b1, 1'b1); tick();
    clear = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("clear_pins", {5'd0, io_out}, 32'h0002_AA55);
    chk("clear_busy", {31'd0, busy}, 32'd0);
    repeat (6) tick();
    chk("clear_no_push", {5'd0, io_out}, 32'h0002_AA55);

    // Reset mid-HOLD with two frames queued: nothing survives.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h10 + i), 8'h81, 1'b1, 1'b1);
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; tick();
    chk("midrst_io_out",   {5'd0, io_out}, 32'd0);
    chk("midrst_io_oeb",   {5'd0, io_oeb}, 32'h07FF_FFFF);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_busy",     {31'd0, busy}, 32'd0);
    chk("midrst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("postrst_pins", {5'd0, io_out}, 32'd0);
    end
    chk("postrst_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
